non_restoring_division_controller: RTL and testbench



---
 rtl/div_ctrl_pkg.sv | 21 ++
 rtl/non_restoring_division_controller_if.sv | 36 +++
 rtl/non_restoring_division_controller.sv | 103 ++++++++++
 tb/tb_non_restoring_division_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the non-restoring division controller and its bench.
// The ERR state exists only when DIV_ZERO_CHECK_EN is defined.
package div_ctrl_pkg;

    localparam int DIV_ITERATIONS = 16;
    localparam int DIV_LATENCY    = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_CORRECT,
        S_STORE,
        S_DONE
`ifdef DIV_ZERO_CHECK_EN
        ,
        S_ERR
`endif
    } div_state_t;

endpackage

// File: rtl/non_restoring_division_controller_if.sv
// Request/status and datapath-control bundle between the controller and its surroundings.
// The master side is the requester plus the datapath; the slave side is the controller.
interface non_restoring_division_controller_if;

    logic start;
    logic complete;
    logic a_sign;
    logic div_by_zero;

    logic select_A;
    logic select_Q;
    logic ld_A;
    logic ld_Q;
    logic shift_left_enable_a;
    logic shift_left_enable_q;
    logic select_add;
    logic count_enable;
    logic ld_rem_quotient;

    logic busy;
    logic done;
    logic div_err;

    modport master (
        output start, complete, a_sign, div_by_zero,
        input  select_A, select_Q, ld_A, ld_Q, shift_left_enable_a, shift_left_enable_q,
        input  select_add, count_enable, ld_rem_quotient, busy, done, div_err
    );

    modport slave (
        input  start, complete, a_sign, div_by_zero,
        output select_A, select_Q, ld_A, ld_Q, shift_left_enable_a, shift_left_enable_q,
        output select_add, count_enable, ld_rem_quotient, busy, done, div_err
    );

endinterface

// File: rtl/non_restoring_division_controller.sv
// Sequencing FSM for the 16-bit non-restoring division datapath.
// Define DIV_ZERO_CHECK_EN to divert zero-divisor requests to a one-cycle ERR state.
module non_restoring_division_controller
    import div_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    non_restoring_division_controller_if.slave bus
);

    div_state_t state;
    div_state_t state_next;

`ifndef DIV_ZERO_CHECK_EN
    logic unused_div_by_zero;
    assign unused_div_by_zero = bus.div_by_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controls are decoded from the state; only the restore load in CORRECT looks at a_sign.
    always_comb begin
        state_next              = state;
        bus.select_A            = 1'b0;
        bus.select_Q            = 1'b0;
        bus.ld_A                = 1'b0;
        bus.ld_Q                = 1'b0;
        bus.shift_left_enable_a = 1'b0;
        bus.shift_left_enable_q = 1'b0;
        bus.select_add          = 1'b0;
        bus.count_enable        = 1'b0;
        bus.ld_rem_quotient     = 1'b0;
        bus.busy                = 1'b0;
        bus.done                = 1'b0;
        bus.div_err             = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
`ifdef DIV_ZERO_CHECK_EN
                    state_next = bus.div_by_zero ? S_ERR : S_LOAD;
`else
                    state_next = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                bus.ld_A   = 1'b1;
                bus.ld_Q   = 1'b1;
                bus.busy   = 1'b1;
                state_next = S_ITER;
            end
            S_ITER: begin
                bus.select_A            = 1'b1;
                bus.select_Q            = 1'b1;
                bus.select_add          = 1'b1;
                bus.shift_left_enable_a = 1'b1;
                bus.shift_left_enable_q = 1'b1;
                bus.ld_A                = 1'b1;
                bus.ld_Q                = 1'b1;
                bus.count_enable        = 1'b1;
                bus.busy                = 1'b1;
                if (bus.complete) begin
                    state_next = S_CORRECT;
                end
            end
            S_CORRECT: begin
                bus.select_A = 1'b1;
                bus.ld_A     = bus.a_sign;
                bus.busy     = 1'b1;
                state_next   = S_STORE;
            end
            S_STORE: begin
                bus.ld_rem_quotient = 1'b1;
                bus.busy            = 1'b1;
                state_next          = S_DONE;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                bus.busy   = 1'b1;
                state_next = S_IDLE;
            end
`ifdef DIV_ZERO_CHECK_EN
            S_ERR: begin
                bus.done    = 1'b1;
                bus.div_err = 1'b1;
                bus.busy    = 1'b1;
                state_next  = S_IDLE;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_non_restoring_division_controller.sv
// Bench for the division controller: a simple datapath model closes the loop and results
// are compared against plain integer division. Honours DIV_ZERO_CHECK_EN.
module tb_non_restoring_division_controller;
    import div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dividend;
    logic [15:0] divisor;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          lat;
    int          ce_cnt;
    int          busy_cnt;
    bit          saw_restore;
    bit          saw_load;
    bit          saw_err;

    int          dp_a;
    logic [15:0] dp_q;
    logic [15:0] dp_m;
    logic [3:0]  dp_count;
    logic [15:0] res_q;
    logic [15:0] res_r;

    non_restoring_division_controller_if bus ();

    non_restoring_division_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.complete    = (dp_count == 4'd15);
    assign bus.a_sign      = (dp_a < 0);
    assign bus.div_by_zero = (divisor == 16'd0);

    wire [11:0] all_outs = {bus.select_A, bus.select_Q, bus.ld_A, bus.ld_Q,
                            bus.shift_left_enable_a, bus.shift_left_enable_q,
                            bus.select_add, bus.count_enable, bus.ld_rem_quotient,
                            bus.busy, bus.done, bus.div_err};

    // One non-restoring step: shift {A,Q} left, then subtract M if A was non-negative, else add.
    function automatic int step_a(input int a, input logic [15:0] q, input logic [15:0] m);
        int shifted;
        shifted = a * 2 + int'(q[15]);
        return (a < 0) ? shifted + int'(m) : shifted - int'(m);
    endfunction

    // Datapath model driven purely by the controller outputs.
    always @(posedge clk) begin
        if (rst) begin
            dp_a     <= 0;
            dp_q     <= '0;
            dp_m     <= '0;
            dp_count <= '0;
            res_q    <= '0;
            res_r    <= '0;
        end else begin
            if (bus.ld_Q && !bus.select_Q) begin
                dp_q <= dividend;
                dp_m <= divisor;
            end
            if (bus.ld_A && !bus.select_A) begin
                dp_a <= 0;
            end else if (bus.ld_A && bus.shift_left_enable_a && bus.select_add) begin
                dp_a <= step_a(dp_a, dp_q, dp_m);
                dp_q <= {dp_q[14:0], step_a(dp_a, dp_q, dp_m) >= 0};
            end else if (bus.ld_A && bus.select_A && !bus.select_add) begin
                dp_a <= dp_a + int'(dp_m);
            end
            if (bus.count_enable) begin
                dp_count <= dp_count + 4'd1;
            end
            if (bus.ld_rem_quotient) begin
                res_q <= dp_q;
                res_r <= dp_a[15:0];
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] dd, input logic [15:0] dv, input bit hold);
        @(negedge clk);
        dividend  = dd;
        divisor   = dv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; a timeout leaves lat at 0.
    task automatic waitDone(input int pulse_at);
        lat = 0; ce_cnt = 0; busy_cnt = 0;
        saw_restore = 1'b0; saw_load = 1'b0; saw_err = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == pulse_at) bus.start = 1'b1;
            else if (k == pulse_at + 1) bus.start = 1'b0;
            if (bus.count_enable) ce_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.ld_A || bus.ld_Q) saw_load = 1'b1;
            if (bus.ld_A && bus.select_A && !bus.select_add && !bus.shift_left_enable_a)
                saw_restore = 1'b1;
            if (bus.done) begin
                lat     = k;
                saw_err = bus.div_err;
                break;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] dd, input logic [15:0] dv);
        check({tag, "_quot"}, int'(res_q), int'(dd / dv));
        check({tag, "_rem"},  int'(res_r), int'(dd % dv));
    endtask

    initial begin
        logic [15:0] ops_dd [3];
        logic [15:0] ops_dv [3];
        logic [15:0] rd;
        logic [15:0] rv;

        rst       = 1'b1;
        bus.start = 1'b0;
        dividend  = '0;
        divisor   = 16'd1;
        repeat (3) @(negedge clk);
        check("reset_outs", int'(all_outs), 0);
        rst = 1'b0;

        applyStimulus(16'd100, 16'd7, 1'b0);
        waitDone(-10);
        check("d100_7_latency", lat, DIV_LATENCY);
        check("d100_7_iters", ce_cnt, DIV_ITERATIONS);
        check("d100_7_busy", busy_cnt, DIV_LATENCY);
        check("d100_7_err", int'(saw_err), 0);
        checkOutput("d100_7", 16'd100, 16'd7);
        @(negedge clk);
        check("d100_7_idle_busy", int'(bus.busy), 0);

        applyStimulus(16'd5, 16'd9, 1'b0);
        waitDone(-10);
        check("d5_9_latency", lat, DIV_LATENCY);
        check("d5_9_restore", int'(saw_restore), 1);
        checkOutput("d5_9", 16'd5, 16'd9);

        applyStimulus(16'hFFFF, 16'd1, 1'b0);
        waitDone(5);
        check("dffff_latency_pulse5", lat, DIV_LATENCY);
        checkOutput("dffff_1", 16'hFFFF, 16'd1);
        applyStimulus(16'hFFFF, 16'd1, 1'b0);
        waitDone(18);
        check("dffff_latency_pulse18", lat, DIV_LATENCY);
        repeat (2) @(negedge clk);
        check("dffff_no_requeue", int'(bus.busy), 0);

        ops_dd[0] = 16'd1000;  ops_dv[0] = 16'd33;
        ops_dd[1] = 16'd12345; ops_dv[1] = 16'd1;
        ops_dd[2] = 16'd7;     ops_dv[2] = 16'd65535;
        applyStimulus(ops_dd[0], ops_dv[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitDone(-10);
            check($sformatf("b2b%0d_period", i), lat, (i == 0) ? DIV_LATENCY : DIV_LATENCY + 1);
            checkOutput($sformatf("b2b%0d", i), ops_dd[i], ops_dv[i]);
            if (i < 2) begin
                dividend = ops_dd[i+1];
                divisor  = ops_dv[i+1];
            end else begin
                bus.start = 1'b0;
            end
        end

        applyStimulus(16'd100, 16'd7, 1'b0);
        repeat (9) @(negedge clk);
        check("mid_reset_in_iter", int'(bus.count_enable), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outs", int'(all_outs), 0);
        rst = 1'b0;
        applyStimulus(16'd100, 16'd7, 1'b0);
        waitDone(-10);
        check("post_reset_latency", lat, DIV_LATENCY);
        checkOutput("post_reset", 16'd100, 16'd7);

        for (int i = 0; i < 6; i++) begin
            rd = 16'($urandom);
            rv = 16'($urandom_range(1, 65535));
            applyStimulus(rd, rv, 1'b0);
            waitDone(-10);
            check($sformatf("rand%0d_latency", i), lat, DIV_LATENCY);
            checkOutput($sformatf("rand%0d", i), rd, rv);
        end

        applyStimulus(16'd42, 16'd0, 1'b0);
        waitDone(-10);
`ifdef DIV_ZERO_CHECK_EN
        check("div0_latency", lat, 1);
        check("div0_err", int'(saw_err), 1);
        check("div0_no_loads", int'(saw_load), 0);
        check("div0_busy", busy_cnt, 1);
`else
        check("div0_latency", lat, DIV_LATENCY);
        check("div0_err", int'(saw_err), 0);
`endif
        @(negedge clk);
        check("final_idle", int'(all_outs), 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
